feed_controller: RTL and testbench

Sequencing controller for the Mini-TPU 4x4 operand memory. It streams 16 operand bytes into the memory over a valid/ready port. On `start`, it drives the memory's per-column read selectors in a diagonal, skewed wavefront so the systolic array receives correctly staggered operands. It also gates the array (clear, enable) and signals completion.

---
 rtl/feed_controller_if.sv | 22 ++
 rtl/feed_controller.sv | 86 ++++++++
 tb/tb_feed_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/feed_controller_if.sv
// feed_if: load stream and operand-memory port of the feed controller
interface feed_if #(parameter int DATA_WIDTH = 8);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  mem_write_enable;
  logic [1:0]            mem_write_line;
  logic [1:0]            mem_write_elem;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [3:0]            mem_read_enable;
  logic [7:0]            mem_read_elem;
  modport master (
    output load_valid, load_data,
    input  load_ready, mem_write_enable, mem_write_line, mem_write_elem, mem_data_in,
    input  mem_read_enable, mem_read_elem
  );
  modport slave (
    input  load_valid, load_data,
    output load_ready, mem_write_enable, mem_write_line, mem_write_elem, mem_data_in,
    output mem_read_enable, mem_read_elem
  );
endinterface

// File: rtl/feed_controller.sv
// feed_controller: loads the 4x4 operand memory and drives a skewed diagonal read wavefront into the systolic array
module feed_controller #(
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  output logic  busy,
  output logic  done,
  output logic  array_clear,
  output logic  array_en,
  feed_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt, ld_cnt, rd_en_nxt;
  logic [7:0] rd_elem_nxt;
  logic       hs;
  assign bus.load_ready = (state == IDLE) && !start;
  assign hs             = bus.load_valid && bus.load_ready;
  assign busy           = state != IDLE;
  assign done           = state == DONE;
  assign array_clear    = state == CLEAR;
  assign array_en       = (state == FEED) || (state == DRAIN);
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 4'd1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = FEED;
      end
      FEED: if (cnt == 4'd6) begin
        cnt_nxt   = '0;
        state_nxt = DRAIN;
      end
      DRAIN: if (cnt == 4'(DRAIN_CYCLES - 1)) begin
        cnt_nxt   = '0;
        state_nxt = DONE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end
  // read selectors are computed from the next step so they land registered in the matching FEED cycle
  always_comb begin
    rd_en_nxt   = '0;
    rd_elem_nxt = '0;
    for (int c = 0; c < 4; c++)
      if (state_nxt == FEED && cnt_nxt >= 4'(c) && cnt_nxt <= 4'(c + 3)) begin
        rd_en_nxt[c]         = 1'b1;
        rd_elem_nxt[2*c +: 2] = 2'(cnt_nxt - 4'(c));
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      ld_cnt               <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_write_line   <= '0;
      bus.mem_write_elem   <= '0;
      bus.mem_data_in      <= '0;
      bus.mem_read_enable  <= '0;
      bus.mem_read_elem    <= '0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      bus.mem_read_enable  <= rd_en_nxt;
      bus.mem_read_elem    <= rd_elem_nxt;
      bus.mem_write_enable <= hs;
      if (hs) begin
        bus.mem_write_line <= ld_cnt[3:2];
        bus.mem_write_elem <= ld_cnt[1:0];
        bus.mem_data_in    <= bus.load_data;
      end
      ld_cnt <= (state_nxt == DONE) ? '0 : ld_cnt + 4'(hs);
    end
endmodule

// File: tb/tb_feed_controller.sv
// tb_feed_controller: directed checks of load, wavefront, collisions, reset and minimum drain
module tb_feed_controller;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic busy, done, array_clear, array_en;
  logic busy1, done1, array_clear1, array_en1;
  int total = 0, bad = 0;
  logic [11:0] feed_tab [7] = '{12'h100, 12'h301, 12'h706, 12'hF1B, 12'hE6C, 12'hCB0, 12'h8C0};
  feed_if #(.DATA_WIDTH(8)) bus ();
  feed_if #(.DATA_WIDTH(8)) bus1 ();
  feed_controller #(.DATA_WIDTH(8), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .array_clear(array_clear), .array_en(array_en), .bus(bus)
  );
  feed_controller #(.DATA_WIDTH(8), .DRAIN_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
    .array_clear(array_clear1), .array_en(array_en1), .bus(bus1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int n, input int first_idx, input logic [7:0] d0);
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = d0 + 8'(i);
      #1;
      chk("load_ready", 32'(bus.load_ready), 32'd1);
      step();
      chk("write", {bus.mem_write_enable, bus.mem_write_line, bus.mem_write_elem, bus.mem_data_in},
          {1'b1, 4'((first_idx + i) % 16), 8'(d0 + 8'(i))});
    end
    bus.load_valid = 1'b0;
  endtask
  task automatic run(input int pulse, input bit collide);
    start          = 1'b1;
    bus.load_valid = collide;
    bus.load_data  = 8'hAA;
    #1;
    chk("ready_at_start", 32'(bus.load_ready), 32'd0);
    step();
    start          = 1'b0;
    bus.load_valid = 1'b0;
    chk("cycle1", {busy, done, array_en, array_clear, bus.mem_read_enable, bus.mem_read_elem}, {4'b1001, 12'h0});
    chk("cycle1_no_write", 32'(bus.mem_write_enable), 32'd0);
    chk("cycle1_min", {busy1, done1, array_en1, array_clear1}, 4'b1001);
    for (int cyc = 2; cyc <= 14; cyc++) begin
      start = (cyc - 1 == pulse);
      step();
      start = 1'b0;
      chk($sformatf("run_c%0d", cyc),
          {busy, done, array_en, array_clear, bus.mem_read_enable, bus.mem_read_elem},
          {cyc <= 13, cyc == 13, cyc >= 2 && cyc <= 12, 1'b0, (cyc <= 8) ? feed_tab[cyc-2] : 12'h0});
      chk($sformatf("min_drain_c%0d", cyc), {busy1, done1, array_en1}, {cyc <= 10, cyc == 10, cyc <= 9});
    end
  endtask
  initial begin
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus1.load_valid = 1'b0;
    bus1.load_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state", {busy, done, array_clear, array_en, bus.mem_write_enable, bus.mem_write_line,
        bus.mem_write_elem, bus.mem_data_in, bus.mem_read_enable, bus.mem_read_elem, bus.load_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    load(16, 0, 8'd1);
    step();
    chk("write_hold", {bus.mem_write_enable, bus.mem_write_line, bus.mem_write_elem, bus.mem_data_in}, {1'b0, 4'hF, 8'd16});
    chk("ld_cnt_wrap", 32'(dut.ld_cnt), 32'd0);
    run(0, 1'b0);
    run(0, 1'b1);
    load(1, 0, 8'h30);
    load(3, 1, 8'h40);
    run(5, 1'b0);
    load(1, 0, 8'h60);
    load(2, 1, 8'h70);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", {busy, done, array_clear, array_en, bus.mem_write_enable, bus.mem_write_line,
        bus.mem_write_elem, bus.mem_data_in, bus.mem_read_enable, bus.mem_read_elem, bus.load_ready}, 32'd1);
    chk("midrun_reset_min", {busy1, done1, array_clear1, array_en1}, 4'b0);
    @(negedge clk) rst_n = 1'b1;
    step();
    load(1, 0, 8'h80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
